// File: rtl/mlp_seq_pow2_pkg.sv
// Shared constants for mlp_seq_pow2: sizes, weight-code type, FSM encodings,
// the constant weight/bias tables and the hidden-layer quantiser.
package mlp_seq_pow2_pkg;

  localparam int N_IN   = 8;
  localparam int IN_W   = 4;
  localparam int N_HID  = 3;
  localparam int N_OUT  = 3;
  localparam int HID_W  = 8;
  localparam int QSHIFT = 2;
  localparam int ACC_W  = 16;

  localparam int OP_W     = (IN_W > HID_W) ? IN_W : HID_W;
  localparam int TERM_W   = $clog2((N_IN > N_HID) ? N_IN : N_HID);
  localparam int NEUR_W   = $clog2((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int IN_IX_W  = $clog2(N_IN);
  localparam int HID_IX_W = $clog2(N_HID);
  localparam int CLS_W    = $clog2(N_OUT);
  localparam int FI_W     = $clog2(ACC_W);

  // Power-of-two weight: zero, or +/-(1 << shift).
  typedef struct packed {
    logic       zero;
    logic       neg;
    logic [3:0] shift;
  } w_code_t;

  localparam int W_CODE_BITS = $bits(w_code_t);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_L0   = 2'd1;
  localparam logic [1:0] S_L1   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Encode an integer weight (0 or +/-2^k) as a weight code.
  function automatic w_code_t wc(input int w);
    w_code_t c;
    int      m;
    c = '0;
    if (w == 0) begin
      c.zero = 1'b1;
    end else begin
      c.neg = (w < 0);
      m = (w < 0) ? -w : w;
      for (int k = 0; k < 16; k++) begin
        if (m == (1 << k)) c.shift = 4'(k);
      end
    end
    return c;
  endfunction

  localparam w_code_t W_ZERO = wc(0);

  localparam w_code_t W0 [N_HID][N_IN] = '{
    '{wc(0),   wc(0),   wc(0),   wc(0),   wc(0),  wc(0),   wc(0),   wc(0)},
    '{wc(64),  wc(-64), wc(64),  wc(64),  wc(64), wc(-16), wc(16),  wc(-16)},
    '{wc(-64), wc(8),   wc(-64), wc(-64), wc(64), wc(4),   wc(-64), wc(16)}
  };

  localparam logic [ACC_W-1:0] B0 [N_HID] = '{
    ACC_W'(-512), ACC_W'(-512), ACC_W'(512)
  };

  localparam w_code_t W1 [N_OUT][N_HID] = '{
    '{wc(0), wc(-64), wc(16)},
    '{wc(0), wc(4),   wc(32)},
    '{wc(0), wc(16),  wc(-32)}
  };

  localparam logic [ACC_W-1:0] B1 [N_OUT] = '{
    ACC_W'(2048), ACC_W'(-2048), ACC_W'(-2048)
  };

  // Saturating quantised ReLU for the hidden layer (acc is two's complement).
  function automatic logic [HID_W-1:0] quant(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] v;
    v = a >> QSHIFT;  // only used when a is non-negative, so logical == arithmetic
    if (a[ACC_W-1])         return '0;
    if (|v[ACC_W-1:HID_W])  return '1;
    return v[HID_W-1:0];
  endfunction

endpackage

// File: rtl/mlp_seq_pow2_mac.sv
// pow2_mac: one shift-add MAC step. Next acc = acc_in +/- (operand << shift),
// or acc_in for a zero code. With FAULT_INJECT_EN defined, one result bit can
// be forced for fault-analysis campaigns.
module pow2_mac
  import mlp_seq_pow2_pkg::*;
(
  input  logic [W_CODE_BITS-1:0] code,
  input  logic [OP_W-1:0]        op,
  input  logic [ACC_W-1:0]       acc_in,
`ifdef FAULT_INJECT_EN
  input  logic                   fi_en,
  input  logic [FI_W-1:0]        fi_bit,
  input  logic                   fi_val,
`endif
  output logic [ACC_W-1:0]       acc_out
);

  w_code_t          c;
  logic [ACC_W-1:0] prod;

  assign c = w_code_t'(code);

  // Shift-add (wrapping) followed by the optional bit override.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    prod    = ACC_W'(op) << c.shift;
    acc_out = acc_in;
    if (!c.zero) acc_out = c.neg ? (acc_in - prod) : (acc_in + prod);
`ifdef FAULT_INJECT_EN
    if (fi_en && (int'(fi_bit) < ACC_W)) acc_out[fi_bit] = fi_val;
`endif
  end

endmodule

// File: rtl/mlp_seq_pow2.sv
// mlp_seq_pow2: folded two-layer power-of-two MLP classifier with a single
// shared MAC, valid/ready handshakes and running argmax.
// Optional feature: define FAULT_INJECT_EN to add fi_en/fi_bit/fi_val ports
// that force one accumulator bit on every accumulator write.
module mlp_seq_pow2
  import mlp_seq_pow2_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*IN_W-1:0]  in_data,
`ifdef FAULT_INJECT_EN
  input  logic                  fi_en,
  input  logic [FI_W-1:0]       fi_bit,
  input  logic                  fi_val,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CLS_W-1:0]      out_class,
  output logic [ACC_W-2:0]      out_score
);

  logic [1:0]            state;
  logic [NEUR_W-1:0]     neuron;
  logic [TERM_W-1:0]     term;
  logic [ACC_W-1:0]      acc;
  logic [N_IN*IN_W-1:0]  sample;
  logic [HID_W-1:0]      hidden [N_HID];

  w_code_t               code_sel;
  logic [ACC_W-1:0]      bias_sel;
  logic [OP_W-1:0]       op_sel;
  logic                  last_term;
  logic                  last_neuron;
  logic [ACC_W-1:0]      acc_in;
  logic [ACC_W-1:0]      acc_next;
  logic [ACC_W-2:0]      score;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);

  // Select weight, bias and operand for the current layer/neuron/term.
  always_comb begin
    code_sel    = W_ZERO;
    bias_sel    = '0;
    op_sel      = '0;
    last_term   = 1'b0;
    last_neuron = 1'b0;
    case (state)
      S_L0: begin
        code_sel    = W0[neuron[HID_IX_W-1:0]][term[IN_IX_W-1:0]];
        bias_sel    = B0[neuron[HID_IX_W-1:0]];
        op_sel      = OP_W'(sample[term*IN_W +: IN_W]);
        last_term   = (term == TERM_W'(N_IN - 1));
        last_neuron = (neuron == NEUR_W'(N_HID - 1));
      end
      S_L1: begin
        code_sel    = W1[neuron[CLS_W-1:0]][term[HID_IX_W-1:0]];
        bias_sel    = B1[neuron[CLS_W-1:0]];
        op_sel      = OP_W'(hidden[term[HID_IX_W-1:0]]);
        last_term   = (term == TERM_W'(N_HID - 1));
        last_neuron = (neuron == NEUR_W'(N_OUT - 1));
      end
      default: ;
    endcase
  end

  // First term of each neuron starts from the bias instead of the running sum.
  assign acc_in = (term == '0) ? bias_sel : acc;
  assign score  = acc_next[ACC_W-1] ? '0 : acc_next[ACC_W-2:0];

  pow2_mac u_mac (
    .code    (code_sel),
    .op      (op_sel),
    .acc_in  (acc_in),
`ifdef FAULT_INJECT_EN
    .fi_en   (fi_en),
    .fi_bit  (fi_bit),
    .fi_val  (fi_val),
`endif
    .acc_out (acc_next)
  );

  // Sequencer: accept sample, walk both layers term by term, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      neuron    <= '0;
      term      <= '0;
      acc       <= '0;
      sample    <= '0;
      out_class <= '0;
      out_score <= '0;
      // NOTE: the hidden register file is small and must read 0 after reset, so it is cleared element by element.
      for (int i = 0; i < N_HID; i++) hidden[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sample <= in_data;
            neuron <= '0;
            term   <= '0;
            state  <= S_L0;
          end
        end
        S_L0: begin
          acc <= acc_next;
          if (last_term) begin
            hidden[neuron[HID_IX_W-1:0]] <= quant(acc_next);
            term <= '0;
            if (last_neuron) begin
              neuron <= '0;
              state  <= S_L1;
            end else begin
              neuron <= neuron + 1'b1;
            end
          end else begin
            term <= term + 1'b1;
          end
        end
        S_L1: begin
          acc <= acc_next;
          if (last_term) begin
            // Strict compare keeps the lower index on ties.
            if ((neuron == '0) || (score > out_score)) begin
              out_class <= neuron[CLS_W-1:0];
              out_score <= score;
            end
            term <= '0;
            if (last_neuron) begin
              neuron <= '0;
              state  <= S_DONE;
            end else begin
              neuron <= neuron + 1'b1;
            end
          end else begin
            term <= term + 1'b1;
          end
        end
        default: begin
          if (out_ready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_seq_pow2.sv
// Self-checking bench for mlp_seq_pow2: directed scenarios plus random samples
// against an integer reference model of the two-layer MLP.
module tb_mlp_seq_pow2;

  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_class;
  logic [14:0] out_score;
`ifdef FAULT_INJECT_EN
  logic        fi_en;
  logic [3:0]  fi_bit;
  logic        fi_val;
`endif

  int total = 0;
  int bad   = 0;

  // Reference weights in plain integers.
  int W0I [3][8] = '{
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{64, -64, 64, 64, 64, -16, 16, -16},
    '{-64, 8, -64, -64, 64, 4, -64, 16}
  };
  int B0I [3] = '{-512, -512, 512};
  int W1I [3][3] = '{'{0, -64, 16}, '{0, 4, 32}, '{0, 16, -32}};
  int B1I [3] = '{2048, -2048, -2048};

  mlp_seq_pow2 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef FAULT_INJECT_EN
    .fi_en     (fi_en),
    .fi_bit    (fi_bit),
    .fi_val    (fi_val),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Integer model: 16-bit wrapping sums, quantised ReLU, ReLU, strict argmax.
  function automatic void model(input logic [31:0] d, output int cls, output int best);
    int h [3];
    int s;
    int v;
    for (int j = 0; j < 3; j++) begin
      s = B0I[j];
      for (int i = 0; i < 8; i++) s += W0I[j][i] * int'(d[i*4 +: 4]);
      s = int'(shortint'(s));
      if (s < 0) h[j] = 0;
      else begin
        v = s / 4;
        h[j] = (v > 255) ? 255 : v;
      end
    end
    cls  = 0;
    best = -1;
    for (int k = 0; k < 3; k++) begin
      s = B1I[k];
      for (int j = 0; j < 3; j++) s += W1I[k][j] * h[j];
      s = int'(shortint'(s));
      if (s < 0) s = 0;
      if (s > best) begin
        best = s;
        cls  = k;
      end
    end
  endfunction

  // Offer one sample, measure latency, check the result, optionally hand it off.
  task automatic run(input string tag, input logic [31:0] d, input int ecls,
                     input int escore, input bit early, input bit hs);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin
      out_ready = early && (lat < 20);
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_class"}, 32'(out_class), ecls);
    chk({tag, "_score"}, 32'(out_score), escore);
    if (hs) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_rdy_after_hs"}, 32'(in_ready), 1);
      chk({tag, "_valid_after_hs"}, 32'(out_valid), 0);
    end
  endtask

  initial begin
    int ecls;
    int escore;
    logic [31:0] d;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef FAULT_INJECT_EN
    fi_en  = 1'b0;
    fi_bit = '0;
    fi_val = 1'b0;
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_class", 32'(out_class), 0);
    chk("rst_out_score", 32'(out_score), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Directed: zero input, then saturating all-15 input.
    run("zero", 32'h0, 0, 4096, 1'b0, 1'b1);
    run("all15", 32'hFFFF_FFFF, 2, 2032, 1'b0, 1'b1);

    // Hold DONE for 10 cycles with a stray in_valid; early out_ready is ignored.
    run("hold", 32'h0, 0, 4096, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_class", 32'(out_class), 0);
      chk("hold_score", 32'(out_score), 4096);
      chk("hold_in_ready", 32'(in_ready), 0);
      in_valid = (i == 3);
      in_data  = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_rdy_after_hs", 32'(in_ready), 1);
    chk("hold_valid_after_hs", 32'(out_valid), 0);

    // Reset at L0 cycle 5 aborts the computation.
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_class", 32'(out_class), 0);
    chk("midrst_out_score", 32'(out_score), 0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 1);
    run("after_rst", 32'h0, 0, 4096, 1'b0, 1'b1);

    // Random samples against the model.
    for (int n = 0; n < 20; n++) begin
      d = $urandom;
      if (n % 3 == 0) d = d | 32'h8888_8888;
      model(d, ecls, escore);
      run("rand", d, ecls, escore, (n % 4 == 1), 1'b1);
    end

`ifdef FAULT_INJECT_EN
    // Sign bit forced on every accumulator write: every score clamps to 0.
    fi_en  = 1'b1;
    fi_bit = 4'd15;
    fi_val = 1'b1;
    run("fault", 32'h0, 0, 0, 1'b0, 1'b1);
    fi_en = 1'b0;
    run("fault_off", 32'h0, 0, 4096, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
